// File: rtl/mix_mem_arbiter.sv
// rtl/mix_mem_arbiter.sv - round-robin/lock arbiter for the single-port MIX main memory
// Define MIX_CPU_PRIORITY_EN to let the CPU (requester 0) pre-empt any held lock.
module mix_mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [2:0]      lock,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      owner,
  output logic            busy,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      owner_q, owner_d;
  logic            busy_q, busy_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic [1:0]      win;
  logic [1:0]      cand1, cand2;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    cand1 = next_idx(owner_q);
    cand2 = next_idx(cand1);
    win   = owner_q;
`ifdef MIX_CPU_PRIORITY_EN
    if (req[0])                               win = 2'd0;
    else if (lock[owner_q] && req[owner_q])   win = owner_q;
`else
    if (lock[owner_q] && req[owner_q])        win = owner_q;
`endif
    else if (req[cand1])                      win = cand1;
    else if (req[cand2])                      win = cand2;
    else                                      win = owner_q;
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = 3'b000;
    rdata_d     = rdata_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        mem_en_d = 1'b0;
        if (|req) begin
          owner_d     = win;
          busy_d      = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = we[win];
          mem_addr_d  = addr[win*AW +: AW];
          mem_wdata_d = wdata[win*DW +: DW];
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        mem_en_d = 1'b0;
        ack_d    = 3'b001 << owner_q;
        state_d  = RESP;
      end
      RESP: begin
        busy_d  = 1'b0;
        if (!mem_we_q) rdata_d = mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ack_q       <= 3'b000;
      rdata_q     <= '0;
      owner_q     <= 2'd0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // The RAM only delivers read data in the ack cycle, so it is forwarded then and held afterwards.
  assign rdata     = ((ack_q != 3'b000) && !mem_we_q) ? mem_rdata : rdata_q;
  assign ack       = ack_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mix_mem_arbiter.sv
// tb/tb_mix_mem_arbiter.sv - self-checking bench for mix_mem_arbiter
module tb_mix_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 31;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req, we, lock;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      ack;
  logic [DW-1:0]   rdata;
  logic [1:0]      owner;
  logic            busy, mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            mem_clear;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [1:0]    who;
    logic          rd;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;
  logic [DW-1:0] last_rd = '0;

  typedef struct {
    int            who;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[8];

  logic [DW-1:0] mem [0:4095];

  mix_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .owner(owner),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      mem[12] <= 31'd7;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every ack pops the oldest expected completion.
  always @(negedge clk) begin
    if (reset === 1'b1 && ack !== 3'b000) begin
      if (sb.size() == 0) chk("unexpected_ack", {61'd0, ack}, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("ack_who", {61'd0, ack}, {61'd0, 3'b001 << mon_e.who});
        chk("ack_owner", {62'd0, owner}, {62'd0, mon_e.who});
        chk("ack_busy", {63'd0, busy}, 64'd1);
        if (mon_e.rd) begin
          chk("rdata", {33'd0, rdata}, {33'd0, mon_e.data});
          last_rd = mon_e.data;
        end else begin
          chk("rdata_hold", {33'd0, rdata}, {33'd0, last_rd});
        end
      end
    end
  end

  task automatic push_exp(input int who, input logic rd, input logic [DW-1:0] d);
    sb_t e;
    e.who = who[1:0];
    e.rd = rd;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_port(input int who, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[who] = w;
    addr[who*AW +: AW] = a;
    wdata[who*DW +: DW] = d;
  endtask

  task automatic wait_ack(output logic [2:0] a, output int t);
    a = 3'b000;
    t = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack !== 3'b000) begin
        a = ack;
        t = cyc;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL ack_timeout: got no ack, expected one within 12 cycles (cycle %0d)", cyc);
  endtask

  // One isolated access with cycle-exact checks of the grant/memory/ack timeline.
  task automatic single_access(input int who, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] exp);
    push_exp(who, !w, exp);
    @(posedge clk); #1;
    set_port(who, w, a, d);
    req[who] = 1'b1;
    @(negedge clk);
    chk("idle_mem_en", {63'd0, mem_en}, 64'd0);
    @(negedge clk);
    chk("t1_mem_en", {63'd0, mem_en}, 64'd1);
    chk("t1_mem_we", {63'd0, mem_we}, {63'd0, w});
    chk("t1_mem_addr", {52'd0, mem_addr}, {52'd0, a});
    if (w) chk("t1_mem_wdata", {33'd0, mem_wdata}, {33'd0, d});
    chk("t1_owner", {62'd0, owner}, who);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("t2_ack", {61'd0, ack}, {61'd0, 3'b001 << who});
    chk("t2_mem_en", {63'd0, mem_en}, 64'd0);
    @(posedge clk); #1;
    req[who] = 1'b0;
    @(negedge clk);
    chk("t3_busy", {63'd0, busy}, 64'd0);
  endtask

  logic [2:0] a1, a2;
  int t1, t2, tp, k, t0;
  logic cpu_done;

  initial begin
    tbl[0] = '{0, 1'b0, 12'd12,   31'd0,          31'd7};
    tbl[1] = '{1, 1'b1, 12'd12,   31'd65,         31'd0};
    tbl[2] = '{0, 1'b0, 12'd12,   31'd0,          31'd65};
    tbl[3] = '{2, 1'b1, 12'd4095, 31'h7FFF_FFFF,  31'd0};
    tbl[4] = '{0, 1'b0, 12'd4095, 31'd0,          31'h7FFF_FFFF};
    tbl[5] = '{1, 1'b1, 12'd0,    31'd5,          31'd0};
    tbl[6] = '{0, 1'b1, 12'd2000, 31'd1234,       31'd0};
    tbl[7] = '{2, 1'b0, 12'd0,    31'd0,          31'd5};

    reset = 1'b0; mem_clear = 1'b1;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {61'd0, ack}, 64'd0);
    chk("rst_rdata", {33'd0, rdata}, 64'd0);
    chk("rst_owner", {62'd0, owner}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_addr", {52'd0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", {33'd0, mem_wdata}, 64'd0);
    reset = 1'b1; mem_clear = 1'b0;

    // Reset asserted in the middle of an IN write to word 12.
    @(posedge clk); #1;
    set_port(1, 1'b1, 12'd12, 31'd99);
    req[1] = 1'b1;
    @(posedge clk); #2;
    chk("mid_mem_en", {63'd0, mem_en}, 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", {ack, owner, busy, mem_en, mem_we}, 64'd0);
    chk("mid_rst_addr", {mem_addr, mem_wdata}, 64'd0);
    chk("mid_rst_rdata", {33'd0, rdata}, 64'd0);
    req = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    chk("mid_rst_mem12", {33'd0, mem[12]}, 64'd7);

    for (int i = 0; i < 8; i++)
      single_access(tbl[i].who, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp);

    // All three requesting with owner=2: round-robin 0,1,2,0 at 3-cycle spacing.
    @(posedge clk); #1;
    push_exp(0, 1'b1, 31'd65);
    push_exp(1, 1'b1, 31'd5);
    push_exp(2, 1'b1, 31'h7FFF_FFFF);
    push_exp(0, 1'b1, 31'd65);
    set_port(0, 1'b0, 12'd12, 31'd0);
    set_port(1, 1'b0, 12'd0, 31'd0);
    set_port(2, 1'b0, 12'd4095, 31'd0);
    req = 3'b111;
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(a1, t1);
      if (i > 0) chk("rr_gap", t1 - tp, 64'd3);
      tp = t1;
    end
    @(posedge clk); #1;
    req = '0;

    // IN holds lock for 16 writes while the CPU keeps requesting (owner=0).
    @(posedge clk); #1;
`ifdef MIX_CPU_PRIORITY_EN
    push_exp(1, 1'b0, 31'd0);
    push_exp(0, 1'b1, 31'd0);
    for (int i = 1; i < 16; i++) push_exp(1, 1'b0, 31'd0);
`else
    for (int i = 0; i < 16; i++) push_exp(1, 1'b0, 31'd0);
    push_exp(0, 1'b1, 31'd391);
`endif
    set_port(0, 1'b0, 12'd130, 31'd0);
    set_port(1, 1'b1, 12'd123, 31'd370);
    lock[1] = 1'b1;
    req[0] = 1'b1;
    req[1] = 1'b1;
    k = 0;
    cpu_done = 1'b0;
    tp = 0;
    while (k < 16 || !cpu_done) begin
      wait_ack(a1, t1);
      if (a1 == 3'b000) break;
      @(posedge clk); #1;
      if (a1[1]) begin
        k++;
        if (k < 16) set_port(1, 1'b1, 12'(123 + k), 31'(3 * (123 + k) + 1));
        else begin req[1] = 1'b0; lock[1] = 1'b0; end
      end
      if (a1[0]) begin req[0] = 1'b0; cpu_done = 1'b1; end
    end
    chk("lock_mem138", {33'd0, mem[138]}, 64'd415);

    single_access(0, 1'b0, 12'd130, 31'd0, 31'd391);

    // Same-cycle OUT read of 4095 and IN write to 0 with owner=0: IN first.
    @(posedge clk); #1;
    push_exp(1, 1'b0, 31'd0);
    push_exp(2, 1'b1, 31'h7FFF_FFFF);
    set_port(1, 1'b1, 12'd0, 31'd77);
    set_port(2, 1'b0, 12'd4095, 31'd0);
    req[1] = 1'b1;
    req[2] = 1'b1;
    t0 = cyc;
    wait_ack(a1, t1);
    chk("pair_first", {61'd0, a1}, 64'b010);
    chk("pair_lat", t1 - t0, 64'd2);
    @(posedge clk); #1;
    req[1] = 1'b0;
    wait_ack(a2, t2);
    chk("pair_second", {61'd0, a2}, 64'b100);
    chk("pair_gap", t2 - t1, 64'd3);
    @(posedge clk); #1;
    req[2] = 1'b0;

    single_access(0, 1'b0, 12'd0, 31'd0, 31'd77);
    single_access(2, 1'b0, 12'd0, 31'd0, 31'd77);

    // Lock on owner 2 without its req reserves nothing: CPU served at full speed.
    lock[2] = 1'b1;
    single_access(0, 1'b0, 12'd2000, 31'd0, 31'd1234);
    lock[2] = 1'b0;

    repeat (4) @(posedge clk);
    chk("sb_empty", sb.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
